// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity-type codes and
// the layout of one receive-FIFO entry.
//   rx_state_e  : receiver FSM states
//   Parity*     : parity_type codes (0/1 none, 2 even, 3 odd)
//   rx_entry_t  : {break, parity_err, frame_err, data[7:0]}, 11 bits
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } rx_state_e;

    localparam logic [1:0] ParityNone = 2'd0;
    localparam logic [1:0] ParityEven = 2'd2;
    localparam logic [1:0] ParityOdd  = 2'd3;

    typedef struct packed {
        logic       brk;
        logic       parity_err;
        logic       frame_err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int unsigned RxEntryWidth = $bits(rx_entry_t);

    // A break is an all-zero character that also failed its stop bit.
    function automatic rx_entry_t pack_entry(input logic [7:0] data, input logic parity_err,
                                             input logic frame_err);
        rx_entry_t e;
        e.brk        = frame_err & (data == 8'h00);
        e.parity_err = parity_err;
        e.frame_err  = frame_err;
        e.data       = data;
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO shared by the UART receive and transmit paths.
//   clock, reset      : clock, asynchronous active-high reset
//   push_i, wdata_i   : write request and data (accepted if not full, or full with a pop)
//   pop_i             : read request (ignored when empty)
//   rdata_o           : head entry, zero when empty
//   full_o, empty_o   : occupancy flags
//   level_o           : number of stored entries
module uart_rx_fifo #(
    parameter int unsigned Width = 11,
    parameter int unsigned Depth = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign level_o = count_q;
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with oversampled 2/3 majority bit detection, 5-8 data bits,
// optional parity, 1/2 stop bits, break detection and an output FIFO.
//   clock, reset                  : clock, asynchronous active-high reset
//   rx_en_i                       : receiver enable; low aborts a frame in progress
//   baud_div_i                    : sample tick period minus one
//   data_bits_i/parity_type_i/nstop_i : frame format, latched at start-bit detection
//   rxd_i                         : asynchronous serial input
//   rd_valid_o/rd_ready_i         : FIFO read handshake
//   rd_data_o, rd_*_o flags       : head entry
//   rx_level_o                    : FIFO occupancy
//   overrun_o/overrun_clr_i       : sticky drop flag and its clear
module uart_rx_buffered #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx_en_i,
    input  logic [15:0]                   baud_div_i,
    input  logic [1:0]                    data_bits_i,
    input  logic [1:0]                    parity_type_i,
    input  logic                          nstop_i,
    input  logic                          rxd_i,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [7:0]                    rd_data_o,
    output logic                          rd_parity_error_o,
    output logic                          rd_frame_error_o,
    output logic                          rd_break_o,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
    output logic                          overrun_o,
    input  logic                          overrun_clr_i
);
    import uart_pkg::*;

    localparam int unsigned SampW = $clog2(OVERSAMPLE);
    localparam logic [SampW-1:0] SampLast = SampW'(OVERSAMPLE - 1);
    localparam logic [SampW-1:0] SampMid0 = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] SampMid1 = SampW'(OVERSAMPLE / 2);
    localparam logic [SampW-1:0] SampMid2 = SampW'(OVERSAMPLE / 2 + 1);

    logic [1:0]       sync_q;
    logic             rxs;
    rx_state_e        state_q;
    logic [15:0]      baud_cnt_q;
    logic [SampW-1:0] samp_q;
    logic [2:0]       cap_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       data_q;
    logic             pe_q, fe_q;
    logic [1:0]       cfg_bits_q, cfg_par_q;
    logic             cfg_nstop_q;
    logic             push_q;
    rx_entry_t        entry_q;

    logic             tick, sample_end, maj_bit, last_data;
    logic             fifo_full, fifo_empty, drop;
    rx_entry_t        head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end
    assign rxs = sync_q[1];

    assign tick       = (state_q != StIdle) && (baud_cnt_q == baud_div_i);
    assign sample_end = tick && (samp_q == SampLast);
    assign maj_bit    = (cap_q[0] & cap_q[1]) | (cap_q[0] & cap_q[2]) | (cap_q[1] & cap_q[2]);
    assign last_data  = (bit_idx_q == ({1'b0, cfg_bits_q} + 3'd4));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            samp_q      <= '0;
            cap_q       <= 3'b111;
            bit_idx_q   <= '0;
            data_q      <= '0;
            pe_q        <= 1'b0;
            fe_q        <= 1'b0;
            cfg_bits_q  <= '0;
            cfg_par_q   <= '0;
            cfg_nstop_q <= 1'b0;
            push_q      <= 1'b0;
            entry_q     <= '0;
        end else begin
            push_q <= 1'b0;

            // Counters only run inside a frame so bit timing is anchored to the start edge.
            if (state_q == StIdle) begin
                baud_cnt_q <= '0;
                samp_q     <= '0;
            end else if (tick) begin
                baud_cnt_q <= '0;
                samp_q     <= (samp_q == SampLast) ? '0 : samp_q + SampW'(1);
            end else begin
                baud_cnt_q <= baud_cnt_q + 16'd1;
            end

            if (tick) begin
                if (samp_q == SampMid0) cap_q[0] <= rxs;
                if (samp_q == SampMid1) cap_q[1] <= rxs;
                if (samp_q == SampMid2) cap_q[2] <= rxs;
            end

            if (state_q != StIdle && !rx_en_i) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_en_i && !rxs) begin
                            state_q     <= StStart;
                            cfg_bits_q  <= data_bits_i;
                            cfg_par_q   <= parity_type_i;
                            cfg_nstop_q <= nstop_i;
                        end
                    end
                    StStart: begin
                        if (sample_end) begin
                            if (!maj_bit) begin
                                state_q   <= StData;
                                bit_idx_q <= '0;
                                data_q    <= '0;
                                pe_q      <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StData: begin
                        if (sample_end) begin
                            data_q[bit_idx_q] <= maj_bit;
                            bit_idx_q         <= bit_idx_q + 3'd1;
                            if (last_data) begin
                                state_q <= cfg_par_q[1] ? StParity : StStop1;
                            end
                        end
                    end
                    StParity: begin
                        if (sample_end) begin
                            pe_q    <= (^data_q) ^ (cfg_par_q == ParityOdd) ^ maj_bit;
                            state_q <= StStop1;
                        end
                    end
                    StStop1: begin
                        if (sample_end) begin
                            fe_q <= ~maj_bit;
                            if (cfg_nstop_q) begin
                                state_q <= StStop2;
                            end else begin
                                entry_q <= pack_entry(data_q, pe_q, ~maj_bit);
                                push_q  <= 1'b1;
                                state_q <= StIdle;
                            end
                        end
                    end
                    StStop2: begin
                        if (sample_end) begin
                            entry_q <= pack_entry(data_q, pe_q, fe_q | ~maj_bit);
                            push_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .Width (RxEntryWidth),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_q),
        .wdata_i (entry_q),
        .pop_i   (rd_ready_i),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (rx_level_o)
    );

    // A full FIFO only drops when the head is not leaving in the same cycle.
    assign drop = push_q & fifo_full & ~rd_ready_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_o <= 1'b0;
        end else if (drop) begin
            overrun_o <= 1'b1;
        end else if (overrun_clr_i) begin
            overrun_o <= 1'b0;
        end
    end

    assign rd_valid_o        = ~fifo_empty;
    assign rd_data_o         = head.data;
    assign rd_parity_error_o = head.parity_err;
    assign rd_frame_error_o  = head.frame_err;
    assign rd_break_o        = head.brk;

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Parametrised UART receiver with a programmable baud tick, a runtime-selectable frame format of 5–8 data bits, 2/3 majority sampling, break detection, and an output FIFO with a valid/ready read handshake. It sits between the serial pin and the peripheral's register/bus interface. Software drains received characters and their error flags from the FIFO instead of polling a single-entry buffer.

## Interface
- OVERSAMPLE, 16: sample ticks per bit; even, ≥8.
- FIFO_DEPTH, 8: FIFO entries; power of two, ≥2.
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- rx_en  in  1  receiver enable.
- baud_div  in  16  tick period minus one; 0 gives a tick every cycle.
- data_bits  in  2  data length = data_bits + 5.
- parity_type  in  2  0/1 none, 2 even, 3 odd.
- nstop  in  1  0: one stop bit, 1: two stop bits.
- rxd  in  1  serial input; asynchronous to clock.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts the head entry.
- rd_data  out  8  head data, right-aligned; unused MSBs are 0.
- rd_parity_error / rd_frame_error / rd_break  out  1 each  head-entry flags.
- rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- overrun_clr  in  1  clears `overrun`.

## Operation
- `rxd` passes through a 2-flop synchroniser to give `rxs`; all logic uses `rxs`.
- Baud counter: counts 0..baud_div; `tick` fires when count == baud_div, and the counter then returns to 0.
- Sample counter: increments on `tick` and wraps at OVERSAMPLE-1.
- `sample_end` = tick & (sample counter == OVERSAMPLE-1).
- `rxs` is captured on ticks where the sample counter equals OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2/3 majority of those three captures.
- FSM states:
  - **Idle**: baud and sample counters are held at 0. Goes to Start when rx_en & ~rxs.
  - **Start**: at sample_end, majority 0 → Data and the bit index clears; majority 1 → Idle (false start, nothing pushed).
  - **Data**: at each sample_end, the majority bit is written to data[bit_idx] and bit_idx increments. After bit data_bits+4, goes to Parity if parity_type[1], else Stop1.
  - **Parity**: at sample_end, parity_error = XOR(received data bits) ^ parity_type[0] ^ bit. Goes to Stop1.
  - **Stop1**: at sample_end, frame_error = ~bit. Goes to Stop2 if nstop; otherwise pushes the entry and goes to Idle.
  - **Stop2**: at sample_end, frame_error |= ~bit. Pushes the entry and goes to Idle.
- Break: set at push when all data bits are 0 and frame_error = 1. The entry is still pushed, with data 0.
- Configuration inputs (data_bits, parity_type, nstop) must be stable while the FSM is not in Idle. The block latches them on the Idle→Start transition.
- rx_en low in any non-Idle state aborts the frame: go to Idle on the next cycle, push nothing, and leave the FIFO untouched.
- FIFO:
  - Pop on rd_valid & rd_ready.
  - A push while full without a same-cycle pop drops the entry and sets `overrun`.
  - A push while full with a same-cycle pop: both happen and no overrun.
  - A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun_clr clears `overrun`. If overrun_clr and a new drop happen in the same cycle, `overrun` is set (set wins).

## Timing
- Reset values:
  - FSM Idle; all counters 0.
  - FIFO empty: rd_valid=0, rx_level=0.
  - rd_data=0 and all rd_* flags 0.
  - overrun=0.
  - Synchroniser flops reset to 1.
- Falling edge of `rxd` to Idle exit: 3 cycles (2 synchroniser + 1 state register).
- Push occurs on the clock edge following the final stop-bit sample_end. rd_valid and rx_level update 1 cycle after that push edge.
- Read data is combinational from the FIFO head. The pop takes effect at the handshake edge.
- With baud_div=0 and OVERSAMPLE=16, one bit lasts exactly 16 cycles.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (Idle, Start, Data, Parity, Stop1, Stop2).
  - Parity-type constants (NONE, EVEN=2, ODD=3).
  - FIFO entry layout {break, parity_err, frame_err, data[7:0]}, 11 bits.
- Sub-module `uart_rx_fifo`: synchronous FIFO parametrised on width and depth, with push/pop/full/empty/level. It is reused by the TX side.

## Test plan
- baud_div=0, 8N1, send 0xA5 → one entry 0xA5, all flags 0; rd_valid rises 1 cycle after the final stop-bit push edge.
- 7E2, send 0x41, then 0x41 with the parity bit flipped → entries 0x41/pe=0 and 0x41/pe=1; 5-bit mode, send 0x1F → rd_data=0x1F.
- Glitch: 0 for 4 samples during Start → return to Idle, rx_level stays 0. Single-sample glitch on a data bit → majority rejects it, data correct.
- Line held low for 12 bit times (8N1) → entry data=0, frame_error=1, break=1.
- FIFO_DEPTH=8, rd_ready=0, send 9 frames → rx_level=8, overrun=1, 9th dropped. Send a frame with a pop in the push cycle → no new overrun. overrun_clr → overrun=0.
- rx_en deasserted mid-Data, then reset mid-frame → no push, FSM Idle; reset empties FIFO and returns all outputs to reset values; next frame received correctly.
